// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the memory-mapped button/output controller.
//   Address map bases, register offsets within the button window and the
//   default parameter values used by mmio_io_ctrl.
package mmio_pkg;

    // Address map
    localparam logic [31:0] MMIO_BTN_ADDR = 32'd1000;
    localparam logic [31:0] MMIO_OUT_ADDR = 32'd2000;

    // Register offsets from the button window base
    localparam logic [31:0] STATUS  = 32'd0;
    localparam logic [31:0] PENDING = 32'd1;
    localparam logic [31:0] MASK    = 32'd2;

    // Default parameter values
    localparam int unsigned MMIO_NUM_BTN    = 4;
    localparam int unsigned MMIO_NUM_OUT    = 8;
    localparam int unsigned MMIO_DEB_CYCLES = 4;

endpackage

// File: rtl/mmio_debounce.sv
// mmio_debounce: one button channel -- 2-flop synchroniser feeding a
// saturating stability counter that moves the debounced level.
// Ports:
//   clock, reset   rising-edge clock, async active-low reset
//   btn_i          raw asynchronous button input
//   level_o        debounced level (registered)
//   rise_c_o       combinational: level goes 0->1 on the coming edge
module mmio_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_c_o
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: count consecutive disagreeing samples, flip level on the last one
    always_comb begin
        sync_d   = {sync_q[0], btn_i};
        level_d  = level_q;
        cnt_d    = '0;
        rise_c_o = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d  = sync_q[1];
                rise_c_o = sync_q[1];
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped debounced buttons with sticky pending bits and
// an output latch, decoded on the processor data-memory bus.
// Optional feature macro: MMIO_IO_CTRL_IRQ_EN adds a mask register at
// BTN_ADDR+2 and a registered irq = |(pending & mask); otherwise irq is 0.
// Ports:
//   clock, reset         rising-edge clock, async active-low reset
//   addr/wren/rden/wdata processor store/load access
//   rdata, hit           combinational load data and address-decode hit
//   btn_in               raw button inputs
//   out_q                output latch
//   irq                  interrupt request
module mmio_io_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned NUM_BTN    = MMIO_NUM_BTN,
    parameter int unsigned NUM_OUT    = MMIO_NUM_OUT,
    parameter int unsigned DEB_CYCLES = MMIO_DEB_CYCLES,
    parameter logic [31:0] BTN_ADDR   = MMIO_BTN_ADDR,
    parameter logic [31:0] OUT_ADDR   = MMIO_OUT_ADDR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic               wren,
    input  logic               rden,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               hit,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_OUT-1:0] out_q,
    output logic               irq
);

    localparam logic [31:0] STAT_A = BTN_ADDR + STATUS;
    localparam logic [31:0] PEND_A = BTN_ADDR + PENDING;

    logic [NUM_BTN-1:0] level, rise;
    logic [NUM_BTN-1:0] pending_q, pending_d, clr_c;
    logic [NUM_OUT-1:0] out_d;
    logic               sel_stat, sel_pend, sel_out, sel_mask;
    logic [31:0]        mask_rd;
    logic               unused_wdata_c;

    for (genvar gi = 0; gi < int'(NUM_BTN); gi++) begin : g_deb
        mmio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clock    (clock),
            .reset    (reset),
            .btn_i    (btn_in[gi]),
            .level_o  (level[gi]),
            .rise_c_o (rise[gi])
        );
    end

    assign sel_stat = (addr == STAT_A);
    assign sel_pend = (addr == PEND_A);
    assign sel_out  = (addr == OUT_ADDR);

    // Pending: write-one-to-clear wins over read-clear; a new rise always wins
    always_comb begin
        clr_c = '0;
        if (sel_pend) begin
            if (wren)      clr_c = wdata[NUM_BTN-1:0];
            else if (rden) clr_c = '1;
        end
        pending_d = (pending_q & ~clr_c) | rise;
        out_d     = out_q;
        if (wren && sel_out) out_d = wdata[NUM_OUT-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            out_q     <= '0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
        end
    end

`ifdef MMIO_IO_CTRL_IRQ_EN
    logic [NUM_BTN-1:0] mask_q, mask_d;
    logic               irq_q;

    assign sel_mask = (addr == BTN_ADDR + MASK);
    assign mask_rd  = 32'(mask_q);

    always_comb begin
        mask_d = mask_q;
        if (wren && sel_mask) mask_d = wdata[NUM_BTN-1:0];
    end

    // irq follows pending/mask one cycle later
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= |(pending_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign sel_mask = 1'b0;
    assign mask_rd  = '0;
    assign irq      = 1'b0;
`endif

    // Load data mux; zero whenever the address is not ours
    always_comb begin
        hit   = sel_stat | sel_pend | sel_out | sel_mask;
        rdata = '0;
        if (sel_stat)      rdata = {16'(pending_q), 16'(level)};
        else if (sel_pend) rdata = 32'(pending_q);
        else if (sel_out)  rdata = 32'(out_q);
        else if (sel_mask) rdata = mask_rd;
    end

    assign unused_wdata_c = ^wdata;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed scenarios plus randomized bus/button traffic,
// all compared every cycle against a behavioural model of the register map.
module tb_mmio_io_ctrl;

    localparam int unsigned NB  = 4;
    localparam int unsigned NO  = 8;
    localparam int unsigned DEB = 4;
    localparam logic [31:0] BA  = 32'd1000;
    localparam logic [31:0] OA  = 32'd2000;

    logic          clock, reset;
    logic [31:0]   addr, wdata, rdata;
    logic          wren, rden, hit, irq;
    logic [NB-1:0] btn_in;
    logic [NO-1:0] out_q;

    mmio_io_ctrl #(
        .NUM_BTN(NB), .NUM_OUT(NO), .DEB_CYCLES(DEB), .BTN_ADDR(BA), .OUT_ADDR(OA)
    ) dut (
        .clock(clock), .reset(reset), .addr(addr), .wren(wren), .rden(rden),
        .wdata(wdata), .rdata(rdata), .hit(hit), .btn_in(btn_in),
        .out_q(out_q), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: a channel's level flips once the input (seen two
    // edges late) has disagreed with it for DEB consecutive samples.
    logic [NB-1:0] m_lvl, m_pend, m_mask;
    logic [NO-1:0] m_out;
    logic          m_irq;
    int            m_run [NB];
    logic [NB-1:0] m_hist [$];

    task automatic m_reset();
        m_lvl = '0; m_pend = '0; m_mask = '0; m_out = '0; m_irq = 1'b0;
        for (int c = 0; c < int'(NB); c++) m_run[c] = 0;
        m_hist.delete();
        m_hist.push_back('0);
        m_hist.push_back('0);
    endtask

    function automatic logic m_hit(input logic [31:0] a);
`ifdef MMIO_IO_CTRL_IRQ_EN
        return (a == BA) || (a == BA + 32'd1) || (a == BA + 32'd2) || (a == OA);
`else
        return (a == BA) || (a == BA + 32'd1) || (a == OA);
`endif
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (a == BA)               return {16'(m_pend), 16'(m_lvl)};
        if (a == BA + 32'd1)       return 32'(m_pend);
        if (a == OA)               return 32'(m_out);
`ifdef MMIO_IO_CTRL_IRQ_EN
        if (a == BA + 32'd2)       return 32'(m_mask);
`endif
        return 32'd0;
    endfunction

    task automatic m_edge(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, input logic [NB-1:0] b);
        logic [NB-1:0] seen, set, clr;
        logic          nxt_irq;
        seen = m_hist.pop_front();
        m_hist.push_back(b);
        set = '0;
        for (int c = 0; c < int'(NB); c++) begin
            if (seen[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == int'(DEB)) begin
                    m_lvl[c] = seen[c];
                    m_run[c] = 0;
                    if (seen[c]) set[c] = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        clr = '0;
        if (a == BA + 32'd1) begin
            if (w)      clr = d[NB-1:0];
            else if (r) clr = '1;
        end
`ifdef MMIO_IO_CTRL_IRQ_EN
        nxt_irq = |(m_pend & m_mask);
        if (w && a == BA + 32'd2) m_mask = d[NB-1:0];
`else
        nxt_irq = 1'b0;
`endif
        m_pend = (m_pend & ~clr) | set;
        if (w && a == OA) m_out = d[NO-1:0];
        m_irq = nxt_irq;
    endtask

    // One bus cycle: drive just after a rising edge, check at the falling edge
    task automatic cycle(input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] d, input logic [NB-1:0] b,
                         output logic [31:0] rd);
        addr = a; rden = r; wren = w; wdata = d; btn_in = b;
        @(negedge clock);
        rd = rdata;
        check("hit",   32'(hit),   32'(m_hit(a)));
        check("rdata", rdata,      m_rdata(a));
        check("out_q", 32'(out_q), 32'(m_out));
        check("irq",   32'(irq),   32'(m_irq));
        @(posedge clock);
        m_edge(a, r, w, d, b);
        #1;
    endtask

    task automatic do_reset(input logic [NB-1:0] b);
        reset = 1'b0; rden = 1'b0; wren = 1'b0; addr = BA; wdata = '0; btn_in = b;
        #1;
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_irq",   32'(irq),   32'd0);
        check("rst_stat",  rdata,      32'd0);
        m_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Edges from first drive of b until channel ch shows its level high
    task automatic measure(input int ch, input logic [NB-1:0] b);
        logic [31:0] rd;
        int lat;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(BA, 1'b0, 1'b0, 32'd0, b, rd);
            if (lat < 0 && rdata[ch]) lat = i;
        end
        check("latency", 32'(lat), 32'(2 + DEB));
        check("pend_set", 32'(rdata[16+ch]), 32'd1);
    endtask

    logic [31:0]   rd;
    logic [NB-1:0] rb;

    initial begin
        reset = 1'b0; addr = '0; rden = 1'b0; wren = 1'b0; wdata = '0; btn_in = '0;
        m_reset();
        @(posedge clock);
        #1;
        do_reset('0);

        // Debounce latency on ch0
        measure(0, 4'b0001);

        // Glitch on ch1 rejected
        repeat (3) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0011, rd);
        repeat (10) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0001, rd);
        check("glitch_lvl",  32'(rdata[1]),  32'd0);
        check("glitch_pend", 32'(rdata[17]), 32'd0);

        // Read-clear of pending = 0101
        repeat (8) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0101, rd);
        cycle(BA + 32'd1, 1'b1, 1'b0, 32'd0, 4'b0101, rd);
        check("rdclr_val", rd, 32'h5);
        cycle(BA + 32'd1, 1'b0, 1'b0, 32'd0, 4'b0101, rd);
        check("rdclr_after", rd, 32'h0);

        // Read-clear coincident with a new ch2 rise: set wins
        repeat (8) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0001, rd);
        repeat (5) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0101, rd);
        cycle(BA + 32'd1, 1'b1, 1'b0, 32'd0, 4'b0101, rd);
        cycle(BA + 32'd1, 1'b0, 1'b0, 32'd0, 4'b0101, rd);
        check("setwins", rd, 32'h4);

        // Simultaneous rden+wren: write (of zero) wins, no read-clear
        cycle(BA + 32'd1, 1'b1, 1'b1, 32'd0, 4'b0101, rd);
        cycle(BA + 32'd1, 1'b0, 1'b0, 32'd0, 4'b0101, rd);
        check("wr_prec", rd, 32'h4);

        // Output latch, ignored status write, and an undecoded address
        cycle(OA, 1'b0, 1'b1, 32'hA5, 4'b0101, rd);
        cycle(OA, 1'b1, 1'b0, 32'd0, 4'b0101, rd);
        check("out_rd", rd, 32'h0000_00A5);
        check("out_q_a5", 32'(out_q), 32'hA5);
        cycle(BA, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0101, rd);
        cycle(32'd1500, 1'b1, 1'b0, 32'd0, 4'b0101, rd);
        check("undec_rd", rd, 32'h0);
        check("undec_hit", 32'(hit), 32'd0);

`ifdef MMIO_IO_CTRL_IRQ_EN
        // Masked interrupt: only ch1 may raise irq
        cycle(BA + 32'd1, 1'b0, 1'b1, 32'hF, 4'b0000, rd);
        cycle(BA + 32'd2, 1'b0, 1'b1, 32'h2, 4'b0000, rd);
        repeat (8) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0001, rd);
        check("irq_masked", 32'(irq), 32'd0);
        repeat (8) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0011, rd);
        check("irq_set", 32'(irq), 32'd1);
        cycle(BA + 32'd1, 1'b0, 1'b1, 32'h2, 4'b0011, rd);
        cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0011, rd);
        cycle(BA, 1'b0, 1'b0, 32'd0, 4'b0011, rd);
        check("irq_clr", 32'(irq), 32'd0);
`endif

        // Reset mid-debounce on ch3, button held through reset
        do_reset('0);
        repeat (3) cycle(BA, 1'b0, 1'b0, 32'd0, 4'b1000, rd);
        do_reset(4'b1000);
        measure(3, 4'b1000);

        // Randomized traffic with occasional resets
        rb = '0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            for (int c = 0; c < int'(NB); c++)
                if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
            case ($urandom_range(0, 6))
                0: a = BA;
                1: a = BA + 32'd1;
                2: a = BA + 32'd2;
                3: a = OA;
                4: a = OA + 32'd1;
                5: a = BA - 32'd1;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 199) == 0) do_reset(rb);
            else cycle(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       $urandom, rb, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
